uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter serializing one byte per request as 8N1: start bit (0), 8 data bits LSB first, one stop bit (1).
Bit period is set at runtime by `baud_div`, in clock cycles per bit; for example, 100 MHz / 9600 baud gives 10416.
Sits behind the APB register block, which drives `tx_en`, `tx_data_in` and `baud_div`, and reads `tx_busy` and `tx_done` as status.

Parameters:
DATA_BITS, 8, data bits per frame; the `tx_data_in` width follows it.
DIV_WIDTH, 32, width of `baud_div` and of the internal bit-period counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
arst_n  in  1  reset, asynchronous assert, active-low.
tx_en  in  1  start request, sampled each rising edge; a one-cycle pulse is sufficient.
tx_data_in  in  DATA_BITS  byte to send; captured on the accepting edge.
baud_div  in  DIV_WIDTH  clocks per bit; captured on the accepting edge.
tx_serial  out  1  serial line; idles high.
tx_busy  out  1  high while a frame is in progress.
tx_done  out  1  single-cycle pulse at frame completion.

Behaviour:
- Reset (`arst_n`=0, asynchronous): `tx_serial`=1, `tx_busy`=0, `tx_done`=0, FSM=IDLE, counters cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high and no `tx_done` is generated.
- FSM states: IDLE, START, DATA, STOP; registered Moore outputs.
- IDLE: `tx_serial`=1, `tx_busy`=0.
  - On an edge with `tx_en`=1: latch `tx_data_in` into a shift register, latch `baud_div`, clear the bit counter, go to START.
  - `tx_serial`=0 and `tx_busy`=1 from the following cycle.
- Request while busy: `tx_en`=1 is ignored; no queueing, and the frame in progress is unaffected.
- Later changes to `tx_data_in` or `baud_div` do not affect a frame already in progress.
- Bit timing: a cycle counter runs 0..D-1, where D = latched `baud_div`. Each bit is held exactly D cycles.
  - `baud_div`=0 is treated as D=1.
- START: `tx_serial`=0 for D cycles, then go to DATA.
- DATA: `tx_serial` = data bit i, with i = 0..DATA_BITS-1, LSB first, each held D cycles. After the last bit, go to STOP.
- STOP: `tx_serial`=1 for D cycles. At the end of the final cycle go to IDLE with `tx_busy`=0 and `tx_done`=1 for exactly one cycle.
- Frame timing: `tx_busy` is high for exactly (DATA_BITS+2)*D cycles (10*D for the default). `tx_done` is high only in the first IDLE cycle.
- Back-to-back frames: a `tx_en` seen while `tx_done`=1 (already IDLE) is accepted. The next start bit then follows the stop bit with no extra idle cycles.
- `tx_done` never coincides with `tx_busy`=1.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP);
  - default DATA_BITS and DIV_WIDTH;
  - line levels IDLE_LVL=1, START_LVL=0, STOP_LVL=1.
  - The receiver reuses this package.
- One natural sub-module, `uart_baud_counter`: loadable divider emitting a one-cycle `bit_tick` every D cycles, with restart on frame start. Shift register and FSM stay in `uart_tx`.

Test Plan:
- Reset with `arst_n`=0 for 2 cycles -> `tx_serial`=1, `tx_busy`=0, `tx_done`=0. No activity for 100 cycles after release with `tx_en`=0.
- `baud_div`=4, pulse `tx_en` with 0xA5 -> line samples per 4-cycle bit are 0,1,0,1,0,0,1,0,1,1. `tx_busy` is high for 40 cycles, then one `tx_done` pulse.
- `baud_div`=10416, send 0xA5 then 0x5A (20 ns gap after `tx_done`) -> each bit is 10416 cycles. Decoded bytes are 0xA5 then 0x5A, with two `tx_done` pulses 104160+ cycles apart.
- During a 0x3C frame, pulse `tx_en` with 0xFF mid-frame and change `baud_div` -> frame unchanged, and no second frame is started.
- `tx_en` asserted on the `tx_done` cycle (`baud_div`=3, 0x01 then 0x80) -> the second start bit begins the next cycle with no idle gap; both frames are correct.
- Assert `arst_n`=0 mid data bit, then release -> line immediately 1, busy 0, no `tx_done`. A subsequent send of 0x55 succeeds.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default widths and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int DIV_WIDTH_DEF = 32;

  // Serial line levels for the idle line and the start and stop bits.
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Register-block side of the UART transmitter.
//
// Handshake: tx_en is a level-sampled request with no ready signal. A request
// is taken on any rising edge where tx_en=1 and the transmitter is idle
// (tx_busy=0, which includes the tx_done cycle); tx_data_in and baud_div are
// captured on that same edge. Requests seen while tx_busy=1 are dropped,
// not queued. tx_done pulses for one cycle when a frame's stop bit ends.
// dbg_state mirrors the transmitter FSM for observation only.
interface uart_tx_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF,
  parameter int DIV_WIDTH = uart_pkg::DIV_WIDTH_DEF
);
  import uart_pkg::*;

  logic                 tx_en;
  logic [DATA_BITS-1:0] tx_data_in;
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 tx_serial;
  logic                 tx_busy;
  logic                 tx_done;
  tx_state_t            dbg_state;

  // Register block: drives requests, reads status and the line.
  modport master (
    output tx_en, tx_data_in, baud_div,
    input  tx_serial, tx_busy, tx_done, dbg_state
  );

  // Transmitter.
  modport slave (
    input  tx_en, tx_data_in, baud_div,
    output tx_serial, tx_busy, tx_done, dbg_state
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Loadable bit-period divider. On load it captures the period (0 is treated
// as 1) and restarts from zero; while run is high it counts 0..D-1 and
// asserts bit_tick on the last cycle of each bit period.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 bit_tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] period_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 last_cycle;

  assign last_cycle = (cnt_q == period_q - ONE);
  assign bit_tick   = run && last_cycle;

  // Period capture on load, otherwise a free-running wrap counter while a frame is active.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      period_q <= ONE;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= (div_in == '0) ? ONE : div_in;
      cnt_q    <= '0;
    end else if (run) begin
      cnt_q <= last_cycle ? '0 : cnt_q + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, DATA_BITS data bits LSB first, one stop
// bit. Bit period comes from the baud divider captured at frame start. All
// outputs are registered; tx_done pulses in the first idle cycle after a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic      clk,
  input  logic      arst_n,
  uart_tx_if.slave  bus
);

  localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 serial_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 accept;
  logic                 bit_tick;

  // A request is only taken from IDLE; while busy it is dropped.
  assign accept = (state_q == IDLE) && bus.tx_en;

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (accept),
    .run      (busy_q),
    .div_in   (bus.baud_div),
    .bit_tick (bit_tick)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= IDLE_LVL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          serial_q <= IDLE_LVL;
          busy_q   <= 1'b0;
          if (bus.tx_en) begin
            shift_q   <= bus.tx_data_in;
            bit_idx_q <= '0;
            serial_q  <= START_LVL;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            serial_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == LAST_IDX) begin
              serial_q <= STOP_LVL;
              state_q  <= STOP;
            end else begin
              serial_q  <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + IDX_ONE;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            serial_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          serial_q <= IDLE_LVL;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // accept is unused outside the divider load; keep it visible for checkers.
  assign bus.tx_serial = serial_q;
  assign bus.tx_busy   = busy_q;
  assign bus.tx_done   = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: driver tasks issue requests and push the expected frame
// (byte, effective bit period) to a queue; a monitor decodes the serial line
// and checks every bit level, its duration and the busy/done status.
module tb_uart_tx;

  localparam int W = 40;  // {effective period[31:0], byte[7:0]}

  logic clk = 1'b0;
  logic arst_n;

  uart_tx_if #(.DATA_BITS(8), .DIV_WIDTH(32)) bus ();

  uart_tx #(.DATA_BITS(8), .DIV_WIDTH(32)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int exp_aborts = 0;
  int mon_aborts = 0;
  int done_count = 0;
  int last_start_cyc = 0;
  int last_done_cyc = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one request starting now; held for one rising edge.
  task automatic issue(input logic [7:0] b, input logic [31:0] d, input bit expect_accept);
    logic [31:0] de;
    bus.tx_en      = 1'b1;
    bus.tx_data_in = b;
    bus.baud_div   = d;
    if (expect_accept) begin
      de = (d == 32'd0) ? 32'd1 : d;
      exp_q.push_back({de, b});
      pushed++;
    end
    @(posedge clk);
    #1;
    bus.tx_en      = 1'b0;
    bus.tx_data_in = 8'($urandom);
    bus.baud_div   = $urandom_range(1, 50);
  endtask

  // Wait (bounded) for a done pulse; returns at the sampling point of the pulse.
  task automatic wait_done(input int budget, input string name);
    bit got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.tx_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout actual=no tx_done required=tx_done within %0d cycles", name, budget);
    end
  endtask

  // Monitor: decode each frame from the line and compare with the queue head.
  initial begin
    logic [W-1:0] item;
    logic [7:0]   b;
    int           d;
    bit           abort;
    logic         lvl;
    logic [2:0]   seen;
    logic [2:0]   want;
    bit           bad;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && bus.tx_serial === 1'b0) begin
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'(bus.tx_serial), 64'(1));
          while (bus.tx_serial === 1'b0) @(negedge clk);
        end else begin
          item  = exp_q.pop_front();
          b     = item[7:0];
          d     = int'(item[39:8]);
          abort = 1'b0;
          for (int k = 0; k < 10 && !abort; k++) begin
            lvl  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            want = {lvl, 1'b1, 1'b0};
            bad  = 1'b0;
            seen = 3'b000;
            for (int c = 0; c < d; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (arst_n !== 1'b1) begin
                abort = 1'b1;
                break;
              end
              if (!bad) seen = {bus.tx_serial, bus.tx_busy, bus.tx_done};
              if ({bus.tx_serial, bus.tx_busy, bus.tx_done} !== want) bad = 1'b1;
            end
            if (!abort)
              check($sformatf("byte%02h_bit%0d_line_busy_done", b, k), 64'(seen), 64'(want));
          end
          if (!abort) begin
            @(negedge clk);
            if (arst_n !== 1'b1) begin
              abort = 1'b1;
            end else begin
              check($sformatf("byte%02h_end_line_busy_done", b),
                    64'({bus.tx_serial, bus.tx_busy, bus.tx_done}), 64'(3'b101));
              last_done_cyc = cyc;
            end
          end
          if (abort) mon_aborts++;
        end
      end
    end
  end

  // Done-pulse invariants: never with busy, never two cycles in a row.
  initial begin
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && bus.tx_done === 1'b1) begin
        done_count++;
        check("done_without_busy", 64'(bus.tx_busy), 64'(0));
        check("done_single_cycle", 64'(prev_done), 64'(0));
      end
      prev_done = (arst_n === 1'b1) ? bus.tx_done : 1'b0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    errors++;
    checks++;
    $display("FAIL watchdog actual=still running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Main stimulus sequence.
  initial begin
    int bad_cnt;
    int d1;
    int c_done;
    int dc_before;
    logic [7:0]  rb;
    logic [31:0] rd;
    int gap;

    arst_n         = 1'b0;
    bus.tx_en      = 1'b0;
    bus.tx_data_in = 8'h00;
    bus.baud_div   = 32'd4;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset_serial", 64'(bus.tx_serial), 64'(1));
    check("reset_busy", 64'(bus.tx_busy), 64'(0));
    check("reset_done", 64'(bus.tx_done), 64'(0));
    check("reset_state", 64'(bus.dbg_state), 64'(0));
    arst_n = 1'b1;

    // Quiet idle with no requests.
    bad_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if ({bus.tx_serial, bus.tx_busy, bus.tx_done} !== 3'b100) bad_cnt++;
    end
    check("idle_quiet_bad_cycles", 64'(bad_cnt), 64'(0));

    // 0xA5 at 4 clocks per bit: busy spans 40 cycles.
    @(posedge clk);
    #1;
    issue(8'hA5, 32'd4, 1'b1);
    wait_done(100, "a5_div4");
    @(posedge clk);
    #1;
    check("a5_div4_busy_len", 64'(last_done_cyc - last_start_cyc), 64'(40));

    // Slow rate, two frames with a two-cycle gap after done.
    issue(8'hA5, 32'd1000, 1'b1);
    wait_done(12000, "slow_a5");
    repeat (2) @(posedge clk);
    #1;
    d1 = last_done_cyc;
    issue(8'h5A, 32'd1000, 1'b1);
    wait_done(12000, "slow_5a");
    @(posedge clk);
    #1;
    check("slow_done_spacing", 64'(last_done_cyc - d1), 64'(10003));

    // Request mid-frame with new data and divider is ignored.
    issue(8'h3C, 32'd8, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    issue(8'hFF, 32'd2, 1'b0);
    wait_done(200, "ignore_3c");
    bad_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx_busy !== 1'b0) bad_cnt++;
    end
    check("no_second_frame_busy_cycles", 64'(bad_cnt), 64'(0));

    // Back-to-back: request on the done cycle.
    @(posedge clk);
    #1;
    issue(8'h01, 32'd3, 1'b1);
    wait_done(100, "b2b_01");
    c_done = cyc;
    issue(8'h80, 32'd3, 1'b1);
    wait_done(100, "b2b_80");
    check("b2b_start_gap", 64'(last_start_cyc - c_done), 64'(1));

    // Reset in the middle of a data bit aborts the frame.
    @(posedge clk);
    #1;
    issue(8'h96, 32'd5, 1'b1);
    exp_aborts++;
    repeat (15) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check("abort_serial", 64'(bus.tx_serial), 64'(1));
    check("abort_busy", 64'(bus.tx_busy), 64'(0));
    check("abort_done", 64'(bus.tx_done), 64'(0));
    dc_before = done_count;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_count), 64'(dc_before));
    @(posedge clk);
    #1;
    issue(8'h55, 32'd4, 1'b1);
    wait_done(100, "after_abort_55");

    // Random frames with random dividers (including 0) and random gaps.
    for (int i = 0; i < 20; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      rb = 8'($urandom);
      rd = $urandom_range(0, 6);
      issue(rb, rd, 1'b1);
      wait_done(120, $sformatf("rand%0d", i));
    end

    repeat (10) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("done_pulse_count", 64'(done_count), 64'(pushed - exp_aborts));
    check("aborted_frames", 64'(mon_aborts), 64'(exp_aborts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
